// File: rtl/up_counter_sequence_monitor.sv
// Tracks a 3-bit up counter (Q2..Q0) and flags any sample that is not previous+1 (mod 8).
// Define UP_COUNTER_SEQ_MON_ERRCNT_EN to build the saturating ERR_CNT register; otherwise ERR_CNT is tied to 0.
module up_counter_sequence_monitor #(
  parameter int WRAP_W   = 8,
  parameter int ERR_W    = 4,
  parameter int RESYNC_N = 2
) (
  input  logic              CLK,
  input  logic              not_RST,
  input  logic              Q0,
  input  logic              Q1,
  input  logic              Q2,
  input  logic              EN,
  output logic              LOCKED,
  output logic              WRAP,
  output logic [WRAP_W-1:0] WRAP_CNT,
  output logic              ERR,
  output logic              ERR_STICKY,
  output logic [ERR_W-1:0]  ERR_CNT
);

  typedef enum logic [1:0] {IDLE, ACQUIRE, TRACK, LOST} state_t;

  state_t            state, state_nxt;
  logic [2:0]        cur, prev, prev_nxt, good, good_nxt, good_inc;
  logic              step_ok;
  logic              locked_nxt, wrap_nxt, err_nxt, sticky_nxt;
  logic [WRAP_W-1:0] wrap_cnt_nxt;

  assign cur      = {Q2, Q1, Q0};
  assign step_ok  = (cur == prev + 3'd1);
  assign good_inc = good + 3'd1;

  always_comb begin
    state_nxt    = state;
    prev_nxt     = prev;
    good_nxt     = good;
    locked_nxt   = LOCKED;
    wrap_nxt     = 1'b0;
    err_nxt      = 1'b0;
    sticky_nxt   = ERR_STICKY;
    wrap_cnt_nxt = WRAP_CNT;
    if (EN) begin
      prev_nxt = cur;
      case (state)
        IDLE: begin
          good_nxt  = 3'd0;
          state_nxt = ACQUIRE;
        end
        ACQUIRE, LOST: begin
          if (!step_ok) begin
            good_nxt = 3'd0;
          end else if (good_inc == 3'(RESYNC_N)) begin
            good_nxt   = 3'd0;
            locked_nxt = 1'b1;
            state_nxt  = TRACK;
          end else begin
            good_nxt = good_inc;
          end
        end
        TRACK: begin
          if (step_ok) begin
            if (prev == 3'd7) begin
              wrap_nxt = 1'b1;
              if (WRAP_CNT != '1) wrap_cnt_nxt = WRAP_CNT + WRAP_W'(1);
            end
          end else begin
            err_nxt    = 1'b1;
            sticky_nxt = 1'b1;
            locked_nxt = 1'b0;
            good_nxt   = 3'd0;
            state_nxt  = LOST;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!not_RST) begin
      state      <= IDLE;
      prev       <= 3'd0;
      good       <= 3'd0;
      LOCKED     <= 1'b0;
      WRAP       <= 1'b0;
      ERR        <= 1'b0;
      ERR_STICKY <= 1'b0;
      WRAP_CNT   <= '0;
    end else begin
      state      <= state_nxt;
      prev       <= prev_nxt;
      good       <= good_nxt;
      LOCKED     <= locked_nxt;
      WRAP       <= wrap_nxt;
      ERR        <= err_nxt;
      ERR_STICKY <= sticky_nxt;
      WRAP_CNT   <= wrap_cnt_nxt;
    end
  end

`ifdef UP_COUNTER_SEQ_MON_ERRCNT_EN
  logic [ERR_W-1:0] err_cnt;

  // Saturating mismatch count, stepped by the same event that raises ERR.
  always_ff @(posedge CLK) begin
    if (!not_RST) begin
      err_cnt <= '0;
    end else if (err_nxt && err_cnt != '1) begin
      err_cnt <= err_cnt + ERR_W'(1);
    end
  end

  assign ERR_CNT = err_cnt;
`else
  assign ERR_CNT = '0;
`endif

endmodule
